// File: rtl/md_unit.sv
// md_unit: iterative unsigned 8-bit multiply/divide unit placed after the register
// file read ports. It takes one shift-add or restoring-divide step per clock and
// returns a registered result, a write address and a one-cycle write enable.
module md_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    input  logic [2:0]       DST,
    output logic             BUSY,
    output logic             DONE,
    output logic             WE_OUT,
    output logic [2:0]       WA_OUT,
    output logic [WIDTH-1:0] RESULT,
    output logic             DIV0
);

    localparam logic [1:0] OP_MULLO = 2'b00;
    localparam logic [1:0] OP_MULHI = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         dst_q;
    logic               dz_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               busy_q;
    logic               done_q;
    logic [2:0]         wa_q;
    logic [WIDTH-1:0]   res_q;
    logic               div0_q;

    logic [WIDTH:0]     add_hi;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH:0]     rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [CNT_W-1:0]   cnt_d;

    // Pick the architectural result from the final iteration values.
    function automatic logic [WIDTH-1:0] pick_result(
        input logic [1:0]         op,
        input logic [2*WIDTH-1:0] prod,
        input logic [WIDTH-1:0]   quo,
        input logic [WIDTH-1:0]   rem,
        input logic               dz,
        input logic [WIDTH-1:0]   a
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_MULLO: r = prod[WIDTH-1:0];
            OP_MULHI: r = prod[2*WIDTH-1:WIDTH];
            OP_DIVU:  r = dz ? {WIDTH{1'b1}} : quo;
            default:  r = dz ? a : rem;
        endcase
        return r;
    endfunction

    // One multiply step and one restoring-divide step, computed every cycle.
    always_comb begin
        // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
        add_hi = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        prod_d = {add_hi, prod_q[WIDTH-1:1]};
        // Restoring divide: shift in the next dividend bit, trial-subtract, keep on non-negative.
        trial  = {rem_q, quo_q[WIDTH-1]} - {2'b00, b_q};
        if (trial[WIDTH+1]) begin
            rem_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = trial[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CNT_W'(1);
    end

    // Control FSM with registered outputs; a zero divisor finishes after a single step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dst_q   <= '0;
            dz_q    <= 1'b0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wa_q    <= '0;
            res_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        a_q     <= SRC_A;
                        b_q     <= SRC_B;
                        op_q    <= OP;
                        dst_q   <= DST;
                        dz_q    <= OP[1] && (SRC_B == '0);
                        prod_q  <= {{WIDTH{1'b0}}, SRC_B};
                        rem_q   <= '0;
                        quo_q   <= SRC_A;
                        cnt_q   <= CNT_W'(WIDTH);
                        div0_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    prod_q <= prod_d;
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= dz_q ? '0 : cnt_d;
                    if (dz_q || (cnt_q == CNT_W'(1))) begin
                        res_q   <= pick_result(op_q, prod_d, quo_d, rem_d[WIDTH-1:0], dz_q, a_q);
                        wa_q    <= dst_q;
                        div0_q  <= dz_q;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign WE_OUT = done_q;
    assign WA_OUT = wa_q;
    assign RESULT = res_q;
    assign DIV0   = div0_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed table of multiply/divide vectors plus hand-written
// sequences for ignored START pulses and an asynchronous mid-run reset.
module tb_md_unit;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [1:0] OP;
    logic [7:0] SRC_A;
    logic [7:0] SRC_B;
    logic [2:0] DST;
    logic       BUSY;
    logic       DONE;
    logic       WE_OUT;
    logic [2:0] WA_OUT;
    logic [7:0] RESULT;
    logic       DIV0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] dst;
        logic [7:0] res;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[13];

    md_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .SRC_A(SRC_A), .SRC_B(SRC_B),
        .DST(DST), .BUSY(BUSY), .DONE(DONE), .WE_OUT(WE_OUT), .WA_OUT(WA_OUT),
        .RESULT(RESULT), .DIV0(DIV0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present START for one edge, then scramble inputs so only latched copies matter.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] dst);
        @(negedge CLK);
        START = 1'b1; OP = op; SRC_A = a; SRC_B = b; DST = dst;
        @(posedge CLK);
        #1;
        START = 1'b0; OP = ~op; SRC_A = ~a; SRC_B = ~b; DST = ~dst;
    endtask

    // Count cycles (negedge samples) from the accepting edge until DONE.
    task automatic wait_done(output int lat, output logic busy1, output logic div01);
        lat = -1; busy1 = 1'bx; div01 = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                busy1 = BUSY;
                div01 = DIV0;
            end
            if (DONE) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int   lat;
        logic b1;
        logic d1;
        issue(v.op, v.a, v.b, v.dst);
        wait_done(lat, b1, d1);
        chk({nm, "_lat"}, lat, v.lat);
        chk({nm, "_busy_start"}, {31'b0, b1}, 32'd1);
        chk({nm, "_div0_clr"}, {31'b0, d1}, 32'd0);
        chk({nm, "_res"}, {24'b0, RESULT}, {24'b0, v.res});
        chk({nm, "_wa"}, {29'b0, WA_OUT}, {29'b0, v.dst});
        chk({nm, "_we"}, {31'b0, WE_OUT}, 32'd1);
        chk({nm, "_div0"}, {31'b0, DIV0}, {31'b0, v.dz});
        @(negedge CLK);
        chk({nm, "_done_off"}, {30'b0, DONE, WE_OUT}, 32'd0);
        chk({nm, "_busy_off"}, {31'b0, BUSY}, 32'd0);
        chk({nm, "_res_hold"}, {24'b0, RESULT}, {24'b0, v.res});
        chk({nm, "_wa_hold"}, {29'b0, WA_OUT}, {29'b0, v.dst});
    endtask

    initial begin
        int ndone;
        int donecyc;
        int nwe;

        //              op     a      b      dst   res    dz lat
        vecs[0]  = '{2'b00, 8'd13,  8'd11, 3'd3, 8'h8F, 1'b0, 9};
        vecs[1]  = '{2'b01, 8'd200, 8'd200, 3'd5, 8'h9C, 1'b0, 9};
        vecs[2]  = '{2'b00, 8'd200, 8'd200, 3'd6, 8'h40, 1'b0, 9};
        vecs[3]  = '{2'b10, 8'd200, 8'd7,  3'd1, 8'h1C, 1'b0, 9};
        vecs[4]  = '{2'b11, 8'd200, 8'd7,  3'd2, 8'h04, 1'b0, 9};
        vecs[5]  = '{2'b10, 8'hFF, 8'h01, 3'd7, 8'hFF, 1'b0, 9};
        vecs[6]  = '{2'b10, 8'h55, 8'h00, 3'd4, 8'hFF, 1'b1, 2};
        vecs[7]  = '{2'b11, 8'h55, 8'h00, 3'd0, 8'h55, 1'b1, 2};
        vecs[8]  = '{2'b00, 8'h00, 8'h99, 3'd1, 8'h00, 1'b0, 9};
        vecs[9]  = '{2'b01, 8'hFF, 8'hFF, 3'd2, 8'hFE, 1'b0, 9};
        vecs[10] = '{2'b11, 8'hFF, 8'h10, 3'd3, 8'h0F, 1'b0, 9};
        vecs[11] = '{2'b10, 8'hFF, 8'h10, 3'd5, 8'h0F, 1'b0, 9};
        vecs[12] = '{2'b10, 8'd5,  8'd9,  3'd6, 8'h00, 1'b0, 9};

        RST = 1'b1; START = 1'b0; OP = 2'b00; SRC_A = 8'h00; SRC_B = 8'h00; DST = 3'd0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_done", {30'b0, DONE, WE_OUT}, 32'd0);
        chk("rst_res", {24'b0, RESULT}, 32'd0);
        chk("rst_wa", {29'b0, WA_OUT}, 32'd0);
        chk("rst_div0", {31'b0, DIV0}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_busy", {31'b0, BUSY}, 32'd0);

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // START pulses during RUN and during the FIN cycle must be ignored.
        issue(2'b00, 8'd3, 8'd5, 3'd2);
        ndone = 0; donecyc = 0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge CLK);
            if (DONE) begin
                ndone++;
                donecyc = i;
            end
            if (i == 3) begin
                START = 1'b1; OP = 2'b00; SRC_A = 8'd7; SRC_B = 8'd7; DST = 3'd6;
            end
            if (i == 4) START = 1'b0;
            if (i == 9) begin
                START = 1'b1; OP = 2'b01; SRC_A = 8'd9; SRC_B = 8'd9; DST = 3'd5;
            end
            if (i == 10) begin
                START = 1'b0;
                chk("ign_busy_after", {31'b0, BUSY}, 32'd0);
            end
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_donecyc", donecyc, 9);
        chk("ign_res", {24'b0, RESULT}, 32'h0F);
        chk("ign_wa", {29'b0, WA_OUT}, 32'd2);

        // Asynchronous reset in the middle of a run discards it and clears all outputs.
        run_vec("pre_rst_dz", '{2'b10, 8'h55, 8'h00, 3'd7, 8'hFF, 1'b1, 2});
        issue(2'b00, 8'd9, 8'd9, 3'd6);
        repeat (4) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_busy", {31'b0, BUSY}, 32'd0);
        chk("arst_done", {30'b0, DONE, WE_OUT}, 32'd0);
        chk("arst_res", {24'b0, RESULT}, 32'd0);
        chk("arst_wa", {29'b0, WA_OUT}, 32'd0);
        chk("arst_div0", {31'b0, DIV0}, 32'd0);
        nwe = 0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (WE_OUT || DONE) nwe++;
        end
        chk("arst_no_we", nwe, 0);
        chk("arst_idle", {31'b0, BUSY}, 32'd0);
        run_vec("post_arst", '{2'b00, 8'd2, 8'd2, 3'd4, 8'h04, 1'b0, 9});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
